hv_adc_thr_mon: RTL and testbench
=================================

Name: hv_adc_thr_mon

Overview:
- Consumes the averaged ADC result stream (data plus valid strobe) from the HV ADC sampling stage.
- Runs one over-voltage (OV) and one under-voltage (UV) detector on that stream.
- Each detector has programmable trip and release thresholds for hysteresis, and a sample-count debounce.
- Outputs level fault flags, one-cycle interrupt pulses and sticky status bits to the HV fault/register logic.
- One instance is used per ADC channel.

Parameters:
- ADC_DW, 10, width of ADC data and of all thresholds.
- DBNC_W, 4, width of the debounce count input and of the internal counters.

Ports:
- i_clk, input, 1, system clock.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_en, input, 1, monitor enable. Low forces synchronous clear of all state.
- i_adc_vld, input, 1, one-cycle strobe; i_adc_data is valid in that cycle.
- i_adc_data, input, ADC_DW, averaged ADC sample, unsigned.
- i_ov_th, input, ADC_DW, OV trip threshold.
- i_ov_rls_th, input, ADC_DW, OV release threshold.
- i_uv_th, input, ADC_DW, UV trip threshold.
- i_uv_rls_th, input, ADC_DW, UV release threshold.
- i_dbnc_num, input, DBNC_W, number of consecutive qualifying samples required. Value 0 is treated as 1.
- i_sts_clr, input, 1, one-cycle pulse that clears both sticky status bits.
- o_ov_flag, output, 1, OV fault level.
- o_uv_flag, output, 1, UV fault level.
- o_ov_irq, output, 1, one-cycle pulse on entry to OV fault.
- o_uv_irq, output, 1, one-cycle pulse on entry to UV fault.
- o_ov_sts, output, 1, sticky OV-occurred bit.
- o_uv_sts, output, 1, sticky UV-occurred bit.

Behaviour:
- Clock and reset:
  - Single clock i_clk; asynchronous active-low reset i_rst_n.
  - Every output and all state reset to 0; both FSMs reset to NORMAL.
- Detector structure:
  - Two independent, identical detectors, each with a 2-state FSM (NORMAL, FAULT) and a DBNC_W-bit counter.
- Qualifying conditions (unsigned compares):
  - OV trip: data > i_ov_th.
  - OV release: data < i_ov_rls_th.
  - UV trip: data < i_uv_th.
  - UV release: data > i_uv_rls_th.
- Counting rules:
  - The counter changes only in cycles with i_adc_vld=1. Non-vld cycles hold all state.
  - NORMAL state: a trip-qualifying sample increments the counter; a non-qualifying sample clears it.
  - FAULT state: a release-qualifying sample increments the counter; a non-qualifying sample clears it.
- Transitions:
  - When a qualifying sample brings the count to max(i_dbnc_num,1), the FSM toggles state and the counter clears.
  - The counter saturates at all-ones; it never wraps.
- Latency:
  - A completing sample in cycle N makes the flag change at the cycle N+1 edge.
  - The flag equals (state==FAULT), registered.
- Interrupts:
  - irq is high exactly in the first cycle the flag is 1 (NORMAL->FAULT only).
  - There is no irq on release.
- Sticky status:
  - Set on NORMAL->FAULT entry; cleared by i_sts_clr.
  - Set and clear in the same cycle: set wins.
- i_dbnc_num changed mid-count: the new value applies from the next sample. If the count already ≥ new target, the next qualifying sample completes.
- Threshold overlap: OV and UV are independent. Misprogrammed thresholds can assert both flags; no arbitration is done.
- i_en=0:
  - Both FSMs go to NORMAL, counters and flags clear, and no irq is generated.
  - Sticky bits are retained (only i_sts_clr and reset clear them).
  - i_en going high restarts counting from 0.
- Thresholds are quasi-static. Changes take effect on the next vld sample, with no resync.
- Reset mid-fault: everything returns to 0 immediately (asynchronously), with no irq.

Test Plan:
1. OV trip:
   - Setup: ov_th=800, ov_rls_th=700, dbnc=3.
   - Stimulus: samples 810, 810, 810, with idle cycles between.
   - Required: o_ov_flag rises the cycle after the 3rd vld; o_ov_irq high exactly 1 cycle; o_ov_sts=1.
2. Debounce break:
   - Setup: dbnc=3.
   - Stimulus: samples 810, 810, 790, 810, 810.
   - Required: no flag. One more 810 sets the flag.
3. Hysteresis release:
   - Setup: in OV fault.
   - Stimulus: samples 750 ×5.
   - Required: flag stays 1.
   - Stimulus: then 690 ×3.
   - Required: flag clears after the 3rd; no irq.
4. UV path and dbnc=0:
   - Setup: uv_th=200, uv_rls_th=250, dbnc=0.
   - Stimulus: a single sample 150.
   - Required: o_uv_flag and o_uv_irq rise the next cycle.
   - Stimulus: then a single 260.
   - Required: flag clears.
5. Enable and sticky:
   - Stimulus: drop i_en during OV fault.
   - Required: flag 0 next cycle, o_ov_sts stays 1.
   - Stimulus: i_sts_clr in the same cycle as a new trip entry.
   - Required: o_ov_sts remains 1.
   - Stimulus: lone i_sts_clr.
   - Required: clears o_ov_sts.
6. Async reset:
   - Stimulus: assert i_rst_n low mid-debounce (count=2) and mid-fault.
   - Required: all outputs 0 immediately.
   - Stimulus: after release, 3 qualifying samples.
   - Required: trip again with a fresh count.

Source files
------------

// File: rtl/hv_adc_thr_mon.sv
// Per-channel HV ADC over/under-voltage monitor: two hysteretic, debounced
// threshold detectors producing level flags, entry interrupts and sticky status.
module hv_adc_thr_mon #(
    parameter int ADC_DW = 10,
    parameter int DBNC_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_adc_vld,
    input  logic [ADC_DW-1:0] i_adc_data,
    input  logic [ADC_DW-1:0] i_ov_th,
    input  logic [ADC_DW-1:0] i_ov_rls_th,
    input  logic [ADC_DW-1:0] i_uv_th,
    input  logic [ADC_DW-1:0] i_uv_rls_th,
    input  logic [DBNC_W-1:0] i_dbnc_num,
    input  logic              i_sts_clr,
    output logic              o_ov_flag,
    output logic              o_uv_flag,
    output logic              o_ov_irq,
    output logic              o_uv_irq,
    output logic              o_ov_sts,
    output logic              o_uv_sts
);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FAULT  = 1'b1
    } state_e;

    localparam logic [DBNC_W-1:0] CNT_ZERO = {DBNC_W{1'b0}};
    localparam logic [DBNC_W-1:0] CNT_ONE  = DBNC_W'(1);
    localparam logic [DBNC_W-1:0] CNT_MAX  = {DBNC_W{1'b1}};

    state_e            ov_state_q, ov_state_d, uv_state_q, uv_state_d;
    logic [DBNC_W-1:0] ov_cnt_q, ov_cnt_d, uv_cnt_q, uv_cnt_d;
    logic              ov_irq_q, ov_irq_d, uv_irq_q, uv_irq_d;
    logic              ov_sts_q, ov_sts_d, uv_sts_q, uv_sts_d;

    logic [DBNC_W-1:0] target_s;
    logic              ov_qual_s, uv_qual_s;
    logic              ov_done_s, uv_done_s;
    logic [DBNC_W-1:0] ov_cnt_nxt_s, uv_cnt_nxt_s;
    logic              ov_entry_s, uv_entry_s;

    // One debounce step: returns {completed, next count}. Using >= lets a
    // target lowered mid-count complete on the very next qualifying sample.
    function automatic logic [DBNC_W:0] dbnc_step(
        input logic              qual,
        input logic [DBNC_W-1:0] cnt,
        input logic [DBNC_W-1:0] target
    );
        logic [DBNC_W-1:0] inc;
        logic              done;
        if (cnt == CNT_MAX) begin
            inc = cnt;
        end else begin
            inc = cnt + CNT_ONE;
        end
        done = qual && (inc >= target);
        if (qual && !done) begin
            return {1'b0, inc};
        end else begin
            return {done, CNT_ZERO};
        end
    endfunction

    // Qualification of the current sample against the threshold relevant to each FSM state
    always_comb begin
        if (i_dbnc_num == CNT_ZERO) begin
            target_s = CNT_ONE;
        end else begin
            target_s = i_dbnc_num;
        end
        if (ov_state_q == ST_NORMAL) begin
            ov_qual_s = (i_adc_data > i_ov_th);
        end else begin
            ov_qual_s = (i_adc_data < i_ov_rls_th);
        end
        if (uv_state_q == ST_NORMAL) begin
            uv_qual_s = (i_adc_data < i_uv_th);
        end else begin
            uv_qual_s = (i_adc_data > i_uv_rls_th);
        end
        {ov_done_s, ov_cnt_nxt_s} = dbnc_step(ov_qual_s, ov_cnt_q, target_s);
        {uv_done_s, uv_cnt_nxt_s} = dbnc_step(uv_qual_s, uv_cnt_q, target_s);
    end

    // Next-state for both detectors; disable clears everything except sticky status
    always_comb begin
        ov_state_d = ov_state_q;
        uv_state_d = uv_state_q;
        ov_cnt_d   = ov_cnt_q;
        uv_cnt_d   = uv_cnt_q;
        ov_entry_s = 1'b0;
        uv_entry_s = 1'b0;
        if (!i_en) begin
            ov_state_d = ST_NORMAL;
            uv_state_d = ST_NORMAL;
            ov_cnt_d   = CNT_ZERO;
            uv_cnt_d   = CNT_ZERO;
        end else if (i_adc_vld) begin
            ov_cnt_d = ov_cnt_nxt_s;
            uv_cnt_d = uv_cnt_nxt_s;
            case (ov_state_q)
                ST_NORMAL: begin
                    if (ov_done_s) begin
                        ov_state_d = ST_FAULT;
                        ov_entry_s = 1'b1;
                    end else begin
                        ov_state_d = ST_NORMAL;
                    end
                end
                ST_FAULT: begin
                    if (ov_done_s) begin
                        ov_state_d = ST_NORMAL;
                    end else begin
                        ov_state_d = ST_FAULT;
                    end
                end
                default: ov_state_d = ST_NORMAL;
            endcase
            case (uv_state_q)
                ST_NORMAL: begin
                    if (uv_done_s) begin
                        uv_state_d = ST_FAULT;
                        uv_entry_s = 1'b1;
                    end else begin
                        uv_state_d = ST_NORMAL;
                    end
                end
                ST_FAULT: begin
                    if (uv_done_s) begin
                        uv_state_d = ST_NORMAL;
                    end else begin
                        uv_state_d = ST_FAULT;
                    end
                end
                default: uv_state_d = ST_NORMAL;
            endcase
        end else begin
            ov_cnt_d = ov_cnt_q;
            uv_cnt_d = uv_cnt_q;
        end
        ov_irq_d = ov_entry_s;
        uv_irq_d = uv_entry_s;
        ov_sts_d = (ov_sts_q & ~i_sts_clr) | ov_entry_s;
        uv_sts_d = (uv_sts_q & ~i_sts_clr) | uv_entry_s;
    end

    // Detector state, counters and registered interrupt/status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_state_q <= ST_NORMAL;
            uv_state_q <= ST_NORMAL;
            ov_cnt_q   <= CNT_ZERO;
            uv_cnt_q   <= CNT_ZERO;
            ov_irq_q   <= 1'b0;
            uv_irq_q   <= 1'b0;
            ov_sts_q   <= 1'b0;
            uv_sts_q   <= 1'b0;
        end else begin
            ov_state_q <= ov_state_d;
            uv_state_q <= uv_state_d;
            ov_cnt_q   <= ov_cnt_d;
            uv_cnt_q   <= uv_cnt_d;
            ov_irq_q   <= ov_irq_d;
            uv_irq_q   <= uv_irq_d;
            ov_sts_q   <= ov_sts_d;
            uv_sts_q   <= uv_sts_d;
        end
    end

    assign o_ov_flag = (ov_state_q == ST_FAULT);
    assign o_uv_flag = (uv_state_q == ST_FAULT);
    assign o_ov_irq  = ov_irq_q;
    assign o_uv_irq  = uv_irq_q;
    assign o_ov_sts  = ov_sts_q;
    assign o_uv_sts  = uv_sts_q;

endmodule

// File: tb/tb_hv_adc_thr_mon.sv
// Directed self-checking bench for hv_adc_thr_mon: one task per scenario,
// expected values worked out by hand from the detector rules.
module tb_hv_adc_thr_mon;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       adc_vld;
    logic [9:0] adc_data;
    logic [9:0] ov_th, ov_rls_th, uv_th, uv_rls_th;
    logic [3:0] dbnc_num;
    logic       sts_clr;
    logic       ov_flag, uv_flag, ov_irq, uv_irq, ov_sts, uv_sts;

    int n_checks;
    int n_fail;

    hv_adc_thr_mon #(.ADC_DW(10), .DBNC_W(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_adc_vld   (adc_vld),
        .i_adc_data  (adc_data),
        .i_ov_th     (ov_th),
        .i_ov_rls_th (ov_rls_th),
        .i_uv_th     (uv_th),
        .i_uv_rls_th (uv_rls_th),
        .i_dbnc_num  (dbnc_num),
        .i_sts_clr   (sts_clr),
        .o_ov_flag   (ov_flag),
        .o_uv_flag   (uv_flag),
        .o_ov_irq    (ov_irq),
        .o_uv_irq    (uv_irq),
        .o_ov_sts    (ov_sts),
        .o_uv_sts    (uv_sts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] d);
        adc_vld  = 1'b1;
        adc_data = d;
        tick();
        adc_vld  = 1'b0;
    endtask

    task automatic clear_state();
        en = 1'b0;
        tick();
        en = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({ov_flag, uv_flag, ov_irq, uv_irq, ov_sts, uv_sts} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_held: got %b expected 000000", {ov_flag, uv_flag, ov_irq, uv_irq, ov_sts, uv_sts});
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({ov_flag, uv_flag, ov_irq, uv_irq, ov_sts, uv_sts} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_released: got %b expected 000000", {ov_flag, uv_flag, ov_irq, uv_irq, ov_sts, uv_sts});
        end
    endtask

    task automatic test_ov_trip();
        ov_th = 10'd800; ov_rls_th = 10'd700; uv_th = 10'd0; uv_rls_th = 10'd0; dbnc_num = 4'd3;
        send(10'd810); tick();
        send(10'd810); tick();
        n_checks++;
        if (ov_flag !== 1'b0) begin
            n_fail++; $display("FAIL ov_trip_early: flag got %b expected 0", ov_flag);
        end
        send(10'd810);
        n_checks++;
        if ({ov_flag, ov_irq, ov_sts} !== 3'b111) begin
            n_fail++; $display("FAIL ov_trip_entry: flag/irq/sts got %b expected 111", {ov_flag, ov_irq, ov_sts});
        end
        tick();
        n_checks++;
        if ({ov_flag, ov_irq} !== 2'b10) begin
            n_fail++; $display("FAIL ov_trip_irq_width: flag/irq got %b expected 10", {ov_flag, ov_irq});
        end
    endtask

    task automatic test_dbnc_break();
        clear_state();
        sts_clr = 1'b1; tick(); sts_clr = 1'b0;
        n_checks++;
        if (ov_sts !== 1'b0) begin
            n_fail++; $display("FAIL dbnc_sts_clr: got %b expected 0", ov_sts);
        end
        send(10'd810); send(10'd810); send(10'd790); send(10'd810); send(10'd810);
        n_checks++;
        if (ov_flag !== 1'b0) begin
            n_fail++; $display("FAIL dbnc_break_noflag: got %b expected 0", ov_flag);
        end
        send(10'd810);
        n_checks++;
        if ({ov_flag, ov_irq} !== 2'b11) begin
            n_fail++; $display("FAIL dbnc_break_trip: flag/irq got %b expected 11", {ov_flag, ov_irq});
        end
    endtask

    task automatic test_hysteresis();
        repeat (5) send(10'd750);
        n_checks++;
        if ({ov_flag, ov_irq} !== 2'b10) begin
            n_fail++; $display("FAIL hyst_hold: flag/irq got %b expected 10", {ov_flag, ov_irq});
        end
        send(10'd690); send(10'd690);
        n_checks++;
        if (ov_flag !== 1'b1) begin
            n_fail++; $display("FAIL hyst_rls_early: got %b expected 1", ov_flag);
        end
        send(10'd690);
        n_checks++;
        if ({ov_flag, ov_irq, ov_sts} !== 3'b001) begin
            n_fail++; $display("FAIL hyst_release: flag/irq/sts got %b expected 001", {ov_flag, ov_irq, ov_sts});
        end
        tick();
        n_checks++;
        if (ov_irq !== 1'b0) begin
            n_fail++; $display("FAIL hyst_no_irq: got %b expected 0", ov_irq);
        end
    endtask

    task automatic test_uv_dbnc0();
        uv_th = 10'd200; uv_rls_th = 10'd250; dbnc_num = 4'd0;
        send(10'd150);
        n_checks++;
        if ({uv_flag, uv_irq, uv_sts, ov_flag} !== 4'b1110) begin
            n_fail++; $display("FAIL uv_trip: uvflag/uvirq/uvsts/ovflag got %b expected 1110", {uv_flag, uv_irq, uv_sts, ov_flag});
        end
        tick();
        n_checks++;
        if ({uv_flag, uv_irq} !== 2'b10) begin
            n_fail++; $display("FAIL uv_irq_width: got %b expected 10", {uv_flag, uv_irq});
        end
        send(10'd260);
        n_checks++;
        if ({uv_flag, uv_irq} !== 2'b00) begin
            n_fail++; $display("FAIL uv_release: got %b expected 00", {uv_flag, uv_irq});
        end
    endtask

    task automatic test_dbnc_change();
        clear_state();
        dbnc_num = 4'd3;
        send(10'd810); send(10'd810);
        dbnc_num = 4'd1;
        send(10'd810);
        n_checks++;
        if ({ov_flag, ov_irq} !== 2'b11) begin
            n_fail++; $display("FAIL dbnc_lowered: flag/irq got %b expected 11", {ov_flag, ov_irq});
        end
    endtask

    task automatic test_overlap();
        clear_state();
        ov_th = 10'd100; ov_rls_th = 10'd50; uv_th = 10'd900; uv_rls_th = 10'd950; dbnc_num = 4'd1;
        send(10'd500);
        n_checks++;
        if ({ov_flag, uv_flag, ov_irq, uv_irq} !== 4'b1111) begin
            n_fail++; $display("FAIL overlap_both: got %b expected 1111", {ov_flag, uv_flag, ov_irq, uv_irq});
        end
        ov_th = 10'd800; ov_rls_th = 10'd700; uv_th = 10'd200; uv_rls_th = 10'd250; dbnc_num = 4'd3;
        clear_state();
    endtask

    task automatic test_enable_sticky();
        sts_clr = 1'b1; tick(); sts_clr = 1'b0;
        n_checks++;
        if ({ov_sts, uv_sts} !== 2'b00) begin
            n_fail++; $display("FAIL sts_clr_both: got %b expected 00", {ov_sts, uv_sts});
        end
        send(10'd810); send(10'd810); send(10'd810);
        en = 1'b0;
        tick();
        n_checks++;
        if ({ov_flag, ov_irq, ov_sts} !== 3'b001) begin
            n_fail++; $display("FAIL en_drop: flag/irq/sts got %b expected 001", {ov_flag, ov_irq, ov_sts});
        end
        en = 1'b1;
        sts_clr = 1'b1; tick(); sts_clr = 1'b0;
        n_checks++;
        if (ov_sts !== 1'b0) begin
            n_fail++; $display("FAIL lone_clr_1: got %b expected 0", ov_sts);
        end
        send(10'd810); send(10'd810);
        sts_clr = 1'b1;
        send(10'd810);
        sts_clr = 1'b0;
        n_checks++;
        if ({ov_flag, ov_irq, ov_sts} !== 3'b111) begin
            n_fail++; $display("FAIL set_wins: flag/irq/sts got %b expected 111", {ov_flag, ov_irq, ov_sts});
        end
        sts_clr = 1'b1; tick(); sts_clr = 1'b0;
        n_checks++;
        if ({ov_flag, ov_sts} !== 2'b10) begin
            n_fail++; $display("FAIL lone_clr_2: flag/sts got %b expected 10", {ov_flag, ov_sts});
        end
    endtask

    task automatic test_async_reset();
        clear_state();
        dbnc_num = 4'd3;
        send(10'd810); send(10'd810);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ov_flag, uv_flag, ov_irq, uv_irq, ov_sts, uv_sts} !== 6'b000000) begin
            n_fail++; $display("FAIL rst_mid_dbnc: got %b expected 000000", {ov_flag, uv_flag, ov_irq, uv_irq, ov_sts, uv_sts});
        end
        #1 rst_n = 1'b1;
        tick();
        send(10'd810); send(10'd810);
        n_checks++;
        if (ov_flag !== 1'b0) begin
            n_fail++; $display("FAIL rst_fresh_count: got %b expected 0", ov_flag);
        end
        send(10'd810);
        n_checks++;
        if ({ov_flag, ov_irq, ov_sts} !== 3'b111) begin
            n_fail++; $display("FAIL rst_retrip: got %b expected 111", {ov_flag, ov_irq, ov_sts});
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ov_flag, uv_flag, ov_irq, uv_irq, ov_sts, uv_sts} !== 6'b000000) begin
            n_fail++; $display("FAIL rst_mid_fault: got %b expected 000000", {ov_flag, uv_flag, ov_irq, uv_irq, ov_sts, uv_sts});
        end
        #1 rst_n = 1'b1;
        tick();
        n_checks++;
        if ({ov_flag, ov_irq, ov_sts} !== 3'b000) begin
            n_fail++; $display("FAIL rst_after_release: got %b expected 000", {ov_flag, ov_irq, ov_sts});
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        en        = 1'b1;
        adc_vld   = 1'b0;
        adc_data  = 10'd0;
        ov_th     = 10'd800;
        ov_rls_th = 10'd700;
        uv_th     = 10'd0;
        uv_rls_th = 10'd0;
        dbnc_num  = 4'd3;
        sts_clr   = 1'b0;
        test_reset();
        test_ov_trip();
        test_dbnc_break();
        test_hysteresis();
        test_uv_dbnc0();
        test_dbnc_change();
        test_overlap();
        test_enable_sticky();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
